// File: rtl/fwd_ctrl_unit_if.sv
// ID-stage to forwarding-controller bus: decoded ID fields in, EX operand selects and stall out.
// Optional perf counters appear when FWD_PERF_EN is defined.
interface fwd_ctrl_unit_if #(
  parameter int AW = 3
`ifdef FWD_PERF_EN
  , parameter int CNT_W = 16
`endif
);
  logic          hold;
  logic          flush;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic          id_use_imm;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic [1:0]    ex_sel_a;
  logic [1:0]    ex_sel_b;
  logic          stall;
`ifdef FWD_PERF_EN
  logic [CNT_W-1:0] fwd_cnt;
  logic [CNT_W-1:0] stall_cnt;
`endif

  modport master (
    output hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_use_imm, id_rd, id_reg_write, id_mem_read,
`ifdef FWD_PERF_EN
    input  fwd_cnt, stall_cnt,
`endif
    input  ex_sel_a, ex_sel_b, stall
  );

  modport slave (
    input  hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_use_imm, id_rd, id_reg_write, id_mem_read,
`ifdef FWD_PERF_EN
    output fwd_cnt, stall_cnt,
`endif
    output ex_sel_a, ex_sel_b, stall
  );
endinterface

// File: rtl/fwd_ctrl_unit.sv
// EX operand forwarding and load-use stall controller with private EX/MEM destination shadows.
// Define FWD_PERF_EN to add saturating forward/stall event counters.
module fwd_ctrl_unit #(
  parameter int AW = 3
`ifdef FWD_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_ctrl_unit_if.slave   bus
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e        state_q;
  logic          ex_v_q, ex_wr_q, ex_ld_q;
  logic [AW-1:0] ex_rd_q;
  logic          mem_v_q, mem_wr_q;
  logic [AW-1:0] mem_rd_q;
  logic [1:0]    sel_a_q, sel_b_q;

  logic [AW-1:0] src_rs  [2];
  logic [1:0]    src_use;
  logic [1:0]    ex_hit, mem_hit;
  logic [1:0]    fwd_sel [2];
  logic          stall_c, kill_id;
  logic [1:0]    sel_a_d, sel_b_d;

  assign src_rs[0]  = bus.id_rs1;
  assign src_rs[1]  = bus.id_rs2;
  assign src_use[0] = bus.id_use_rs1;
  assign src_use[1] = bus.id_use_rs2;

  // r0 is hardwired zero, so it never matches a producer
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign ex_hit[gi]  = src_use[gi] && (src_rs[gi] != '0) && ex_v_q && ex_wr_q &&
                         (ex_rd_q == src_rs[gi]);
    assign mem_hit[gi] = src_use[gi] && (src_rs[gi] != '0) && mem_v_q && mem_wr_q &&
                         (mem_rd_q == src_rs[gi]);
    assign fwd_sel[gi] = ex_hit[gi] ? 2'b01 : (mem_hit[gi] ? 2'b10 : 2'b00);
  end

  assign stall_c = (state_q == RUN) && bus.id_valid && ex_ld_q && (|ex_hit) && !bus.flush;
  assign kill_id = bus.flush || stall_c || !bus.id_valid;
  assign sel_a_d = kill_id ? 2'b00 : fwd_sel[0];
  assign sel_b_d = kill_id ? 2'b00 : (bus.id_use_imm ? 2'b11 : fwd_sel[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      ex_v_q   <= 1'b0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= '0;
      sel_a_q  <= 2'b00;
      sel_b_q  <= 2'b00;
    end else if (!bus.hold) begin
      mem_v_q  <= ex_v_q;
      mem_wr_q <= ex_wr_q;
      mem_rd_q <= ex_rd_q;
      ex_v_q   <= !kill_id;
      ex_wr_q  <= bus.id_reg_write;
      ex_ld_q  <= bus.id_mem_read;
      ex_rd_q  <= bus.id_rd;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      // STALL lasts exactly one cycle: by then the load sits in MEM and forwards as 10
      if (bus.flush) begin
        state_q <= RUN;
      end else begin
        case (state_q)
          RUN:     state_q <= stall_c ? STALL : RUN;
          STALL:   state_q <= RUN;
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign bus.ex_sel_a = sel_a_q;
  assign bus.ex_sel_b = sel_b_q;
  assign bus.stall    = stall_c;

`ifdef FWD_PERF_EN
  logic [CNT_W-1:0] fwd_cnt_q, stall_cnt_q;
  logic             fwd_now;

  assign fwd_now = (sel_a_q[0] ^ sel_a_q[1]) || (sel_b_q[0] ^ sel_b_q[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (!bus.hold) begin
      if (fwd_now && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
      if (stall_c && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.fwd_cnt   = fwd_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Bench for fwd_ctrl_unit: directed vector table, reset-in-flight sequence, then random traffic
// checked against a pipeline-list reference model.
module tb_fwd_ctrl_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_ctrl_unit_if bus ();
  fwd_ctrl_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic       hold, flush, v;
    logic [2:0] rs1, rs2;
    logic       u1, u2, imm;
    logic [2:0] rd;
    logic       wr, ld;
  } in_t;

  typedef struct {
    in_t        i;
    logic       st;
    logic [1:0] a, b;
  } vec_t;

  typedef struct {
    logic       v, wr, ld;
    logic [2:0] rd;
  } prod_t;

  int checks = 0;
  int errors = 0;

  // Reference: list of in-flight producers, index 0 = youngest (in EX), 1 = in MEM
  prod_t      pipe [2];
  logic [1:0] m_a, m_b;
  int         m_fwd, m_stc;

  function automatic in_t mk(logic v, logic [2:0] rs1, logic u1, logic [2:0] rs2, logic u2,
                             logic imm, logic [2:0] rd, logic wr, logic ld);
    in_t r;
    r.hold = 1'b0; r.flush = 1'b0; r.v = v;
    r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.imm = imm;
    r.rd = rd; r.wr = wr; r.ld = ld;
    return r;
  endfunction

  function automatic in_t i_add(logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    return mk(1'b1, rs1, 1'b1, rs2, 1'b1, 1'b0, rd, 1'b1, 1'b0);
  endfunction
  function automatic in_t i_lw(logic [2:0] rd, logic [2:0] rs1);
    return mk(1'b1, rs1, 1'b1, 3'd0, 1'b0, 1'b1, rd, 1'b1, 1'b1);
  endfunction
  function automatic in_t i_addi(logic [2:0] rd, logic [2:0] rs1);
    return mk(1'b1, rs1, 1'b1, 3'd0, 1'b0, 1'b1, rd, 1'b1, 1'b0);
  endfunction
  function automatic in_t i_bub();
    return mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endfunction
  function automatic in_t w_hold(in_t x);
    in_t r = x;
    r.hold = 1'b1;
    return r;
  endfunction
  function automatic in_t w_flush(in_t x);
    in_t r = x;
    r.flush = 1'b1;
    return r;
  endfunction
  function automatic vec_t vv(in_t i, logic st, logic [1:0] a, logic [1:0] b);
    vec_t r;
    r.i = i; r.st = st; r.a = a; r.b = b;
    return r;
  endfunction

  function automatic logic [1:0] m_src(logic u, logic [2:0] rs);
    if (!u || rs == 3'd0) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == rs)
        return (k == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_stall(in_t x);
    if (!x.v || x.flush) return 1'b0;
    return pipe[0].v && pipe[0].ld &&
           (m_src(x.u1, x.rs1) == 2'b01 || m_src(x.u2, x.rs2) == 2'b01);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) pipe[k] = '{1'b0, 1'b0, 1'b0, 3'd0};
    m_a = 2'b00; m_b = 2'b00; m_fwd = 0; m_stc = 0;
  endtask

  task automatic m_edge(in_t x);
    logic st, kill;
    logic [1:0] na, nb;
    if (x.hold) return;
    st   = m_stall(x);
    kill = st || x.flush || !x.v;
    if (st) m_stc++;
    if (m_a == 2'b01 || m_a == 2'b10 || m_b == 2'b01 || m_b == 2'b10) m_fwd++;
    na = kill ? 2'b00 : m_src(x.u1, x.rs1);
    nb = kill ? 2'b00 : (x.imm ? 2'b11 : m_src(x.u2, x.rs2));
    pipe[1] = pipe[0];
    pipe[0] = '{!kill, x.wr, x.ld, x.rd};
    m_a = na; m_b = nb;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(in_t x);
    bus.hold = x.hold; bus.flush = x.flush; bus.id_valid = x.v;
    bus.id_rs1 = x.rs1; bus.id_rs2 = x.rs2;
    bus.id_use_rs1 = x.u1; bus.id_use_rs2 = x.u2; bus.id_use_imm = x.imm;
    bus.id_rd = x.rd; bus.id_reg_write = x.wr; bus.id_mem_read = x.ld;
  endtask

  // One cycle: stall checked mid-cycle, selects checked just after the edge
  task automatic step(input in_t x, input logic use_tab, input logic e_st,
                      input logic [1:0] e_a, input logic [1:0] e_b, input int idx);
    logic xs;
    logic [1:0] xa, xb;
    @(negedge clk);
    drive(x);
    #1;
    xs = use_tab ? e_st : m_stall(x);
    chk("stall", idx, 32'(bus.stall), 32'(xs));
    @(posedge clk);
    m_edge(x);
    #1;
    xa = use_tab ? e_a : m_a;
    xb = use_tab ? e_b : m_b;
    chk("sel_a", idx, 32'(bus.ex_sel_a), 32'(xa));
    chk("sel_b", idx, 32'(bus.ex_sel_b), 32'(xb));
    $display("txn %0d hold=%b flush=%b v=%b stall=%b sel_a=%0d sel_b=%0d",
             idx, x.hold, x.flush, x.v, bus.stall, bus.ex_sel_a, bus.ex_sel_b);
  endtask

  vec_t tab [31];

  initial begin
    tab[0]  = vv(i_add(3'd1, 3'd2, 3'd3), 1'b0, 2'b00, 2'b00);
    tab[1]  = vv(i_add(3'd2, 3'd1, 3'd3), 1'b0, 2'b01, 2'b00);
    tab[2]  = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[3]  = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[4]  = vv(i_add(3'd1, 3'd2, 3'd3), 1'b0, 2'b00, 2'b00);
    tab[5]  = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[6]  = vv(i_add(3'd4, 3'd5, 3'd1), 1'b0, 2'b00, 2'b10);
    tab[7]  = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[8]  = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[9]  = vv(i_add(3'd3, 3'd1, 3'd2), 1'b0, 2'b00, 2'b00);
    tab[10] = vv(i_add(3'd3, 3'd1, 3'd2), 1'b0, 2'b00, 2'b00);
    tab[11] = vv(i_add(3'd6, 3'd3, 3'd3), 1'b0, 2'b01, 2'b01);
    tab[12] = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[13] = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[14] = vv(i_lw(3'd4, 3'd2), 1'b0, 2'b00, 2'b11);
    tab[15] = vv(i_add(3'd5, 3'd2, 3'd4), 1'b1, 2'b00, 2'b00);
    tab[16] = vv(i_add(3'd5, 3'd2, 3'd4), 1'b0, 2'b00, 2'b10);
    tab[17] = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[18] = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[19] = vv(i_add(3'd0, 3'd1, 3'd2), 1'b0, 2'b00, 2'b00);
    tab[20] = vv(i_addi(3'd7, 3'd0), 1'b0, 2'b00, 2'b11);
    tab[21] = vv(i_lw(3'd4, 3'd2), 1'b0, 2'b00, 2'b11);
    tab[22] = vv(w_flush(i_add(3'd5, 3'd4, 3'd4)), 1'b0, 2'b00, 2'b00);
    tab[23] = vv(i_bub(), 1'b0, 2'b00, 2'b00);
    tab[24] = vv(i_add(3'd1, 3'd2, 3'd3), 1'b0, 2'b00, 2'b00);
    tab[25] = vv(i_lw(3'd2, 3'd1), 1'b0, 2'b01, 2'b11);
    tab[26] = vv(w_hold(i_add(3'd3, 3'd2, 3'd0)), 1'b1, 2'b01, 2'b11);
    tab[27] = vv(w_hold(i_add(3'd3, 3'd2, 3'd0)), 1'b1, 2'b01, 2'b11);
    tab[28] = vv(w_hold(i_add(3'd3, 3'd2, 3'd0)), 1'b1, 2'b01, 2'b11);
    tab[29] = vv(i_add(3'd3, 3'd2, 3'd0), 1'b1, 2'b00, 2'b00);
    tab[30] = vv(i_add(3'd3, 3'd2, 3'd0), 1'b0, 2'b10, 2'b00);

    drive(i_bub());
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", 0, 32'(bus.ex_sel_a), 32'd0);
    chk("rst_sel_b", 0, 32'(bus.ex_sel_b), 32'd0);
    chk("rst_stall", 0, 32'(bus.stall), 32'd0);
`ifdef FWD_PERF_EN
    chk("rst_stall_cnt", 0, 32'(bus.stall_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 31; t++) begin
      step(tab[t].i, 1'b1, tab[t].st, tab[t].a, tab[t].b, t);
`ifdef FWD_PERF_EN
      if (t == 16) chk("stall_cnt_loaduse", t, 32'(bus.stall_cnt), 32'd1);
`endif
    end

    // Reset asserted between edges while a load-use stall is pending
    step(i_bub(), 1'b0, 1'b0, 2'b00, 2'b00, 100);
    step(i_lw(3'd4, 3'd2), 1'b0, 1'b0, 2'b00, 2'b00, 101);
    @(negedge clk);
    drive(i_add(3'd5, 3'd2, 3'd4));
    #1;
    chk("pre_rst_stall", 102, 32'(bus.stall), 32'd1);
    chk("pre_rst_sel_b", 102, 32'(bus.ex_sel_b), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 103, 32'(bus.stall), 32'd0);
    chk("mid_rst_sel_a", 103, 32'(bus.ex_sel_a), 32'd0);
    chk("mid_rst_sel_b", 103, 32'(bus.ex_sel_b), 32'd0);
    m_reset();
    @(negedge clk);
    drive(i_bub());
    rst_n = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      in_t r;
      r.hold  = ($urandom_range(0, 9) == 0);
      r.flush = ($urandom_range(0, 11) == 0);
      r.v     = ($urandom_range(0, 4) != 0);
      r.rs1   = 3'($urandom_range(0, 3));
      r.rs2   = 3'($urandom_range(0, 3));
      r.rd    = 3'($urandom_range(0, 3));
      r.u1    = 1'($urandom_range(0, 1));
      r.u2    = 1'($urandom_range(0, 1));
      r.imm   = ($urandom_range(0, 3) == 0);
      r.ld    = ($urandom_range(0, 2) == 0);
      r.wr    = r.ld | 1'($urandom_range(0, 1));
      step(r, 1'b0, 1'b0, 2'b00, 2'b00, 1000 + n);
    end

`ifdef FWD_PERF_EN
    chk("fwd_cnt", 9999, 32'(bus.fwd_cnt), 32'(m_fwd));
    chk("stall_cnt", 9999, 32'(bus.stall_cnt), 32'(m_stc));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
